// File: rtl/sram_req_arbiter.sv
// Shares one sram-like port between fetch and load/store requesters.
// Routes in-order returns back to their issuer via an owner FIFO.
module sram_req_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        err_unexpected_ok
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_C = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] SLIM_C = SW'(STARVE_LIMIT);

  typedef enum logic {
    ID_INST = 1'b0,
    ID_DATA = 1'b1
  } owner_e;

  logic                       lock_valid_q, lock_valid_d;
  owner_e                     lock_id_q, lock_id_d;
  logic [MAX_OUTSTANDING-1:0] own_q, own_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic [SW-1:0]              starve_q, starve_d;
  logic                       err_q, err_d;

  owner_e winner;
  logic   lock_hit;
  logic   data_wins;
  logic   req;
  logic   accept;
  logic   ret;
  logic   pop;
  logic   head;

  always_comb begin
    lock_hit  = lock_valid_q &
                ((lock_id_q == ID_DATA) ? data_req : inst_req);
    data_wins = data_req &
                ~(inst_req & (starve_q == SLIM_C));
    if (lock_hit)
      winner = lock_id_q;
    else
      winner = data_wins ? ID_DATA : ID_INST;
    req    = resetn & (inst_req | data_req) &
             (count_q != FULL_C);
    accept = req & m_addr_ok;
    ret    = resetn & m_data_ok;
    pop    = ret & (count_q != '0);
    head   = own_q[rd_ptr_q];
  end

  // Fields follow the winner; a fetch is always a 4-byte read.
  always_comb begin
    m_req   = req;
    m_wr    = 1'b0;
    m_size  = 2'd0;
    m_wstrb = 4'd0;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    if (resetn) begin
      if (winner == ID_DATA) begin
        m_wr    = data_wr;
        m_size  = data_size;
        m_wstrb = data_wstrb;
        m_addr  = data_addr;
        m_wdata = data_wdata;
      end else begin
        m_size  = 2'd2;
        m_addr  = inst_addr;
      end
    end
  end

  assign inst_addr_ok      = accept & (winner == ID_INST);
  assign data_addr_ok      = accept & (winner == ID_DATA);
  assign inst_data_ok      = pop & ~head;
  assign data_data_ok      = pop & head;
  assign rdata             = resetn ? m_rdata : 32'd0;
  assign err_unexpected_ok = err_q;

  always_comb begin
    lock_valid_d = req & ~m_addr_ok;
    lock_id_d    = lock_valid_d ? winner : lock_id_q;

    own_d    = own_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      own_d[wr_ptr_q] = (winner == ID_DATA);
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    starve_d = starve_q;
    if (!inst_req)
      starve_d = '0;
    else if (accept && winner == ID_INST)
      starve_d = '0;
    else if (accept && starve_q != SLIM_C)
      starve_d = starve_q + SW'(1);

    err_d = err_q | (ret & (count_q == '0));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_valid_q <= 1'b0;
      lock_id_q    <= ID_INST;
      own_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      own_q        <= own_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      err_q        <= err_d;
    end
  end

endmodule
